// File: rtl/cpu_test_harness_ctrl_pkg.sv
// Shared types and helpers for the CPU test harness controller.
package cpu_test_harness_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PAD,
    ST_RUN,
    ST_DUMP,
    ST_DONE
  } state_e;

  localparam int   DEF_WORD_W        = 32;
  localparam logic DEF_END_INSTR_BIT = 1'b1;  // END_INSTR is this bit replicated

  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/harness_skid_buf.sv
// Two-entry valid/ready buffer; absorbs read data already in flight when the consumer stalls.
module harness_skid_buf
  import cpu_test_harness_ctrl_pkg::*;
#(
  parameter int W = DEF_WORD_W + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] ent_q [2];
  logic [1:0]   count_q;
  logic         wr_idx_q;
  logic         rd_idx_q;
  logic         push;
  logic         pop;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = ent_q[rd_idx_q];
  assign count_o     = count_q;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      count_q  <= '0;
      wr_idx_q <= 1'b0;
      rd_idx_q <= 1'b0;
    end else begin
      if (push) begin
        ent_q[wr_idx_q] <= in_data_i;
        wr_idx_q        <= ~wr_idx_q;
      end
      if (pop) rd_idx_q <= ~rd_idx_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/cpu_test_harness_ctrl.sv
// Runs one CPU test: load program into IMEM, pad with END_INSTR, run CPU, stream DMEM out.
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | accepting program words into IMEM
// PAD   | filling remaining IMEM slots with END_INSTR
// RUN   | CPU released until halt or cycle budget
// DUMP  | reading DMEM out through the skid buffer
// DONE  | finished, results held until next start
module cpu_test_harness_ctrl
  import cpu_test_harness_ctrl_pkg::*;
#(
  parameter int                WORD_W     = DEF_WORD_W,
  parameter int                IMEM_DEPTH = 512,
  parameter int                DMEM_DEPTH = 512,
  parameter int                MAX_CYCLES = 100,
  parameter logic [WORD_W-1:0] END_INSTR  = {WORD_W{DEF_END_INSTR_BIT}}
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               start,
  input  logic                               ld_valid,
  output logic                               ld_ready,
  input  logic [WORD_W-1:0]                  ld_data,
  input  logic                               ld_last,
  output logic                               imem_we,
  output logic [addr_w(IMEM_DEPTH)-1:0]      imem_addr,
  output logic [WORD_W-1:0]                  imem_wdata,
  output logic                               cpu_run,
  input  logic                               cpu_halt,
  output logic                               dmem_re,
  output logic [addr_w(DMEM_DEPTH)-1:0]      dmem_addr,
  input  logic [WORD_W-1:0]                  dmem_rdata,
  output logic                               dp_valid,
  input  logic                               dp_ready,
  output logic [WORD_W-1:0]                  dp_data,
  output logic                               dp_last,
  output logic                               busy,
  output logic                               done,
  output logic                               timeout,
  output logic                               load_ovf,
  output logic [addr_w(MAX_CYCLES+1)-1:0]    run_cycles
);

  localparam int IA_W = addr_w(IMEM_DEPTH);
  localparam int DA_W = addr_w(DMEM_DEPTH);
  localparam int RC_W = addr_w(MAX_CYCLES + 1);
  localparam logic [IA_W:0]   IMEM_FULL = (IA_W+1)'(IMEM_DEPTH);
  localparam logic [IA_W:0]   IMEM_LAST = (IA_W+1)'(IMEM_DEPTH - 1);
  localparam logic [DA_W:0]   DMEM_FULL = (DA_W+1)'(DMEM_DEPTH);
  localparam logic [DA_W:0]   DMEM_LAST = (DA_W+1)'(DMEM_DEPTH - 1);
  localparam logic [RC_W-1:0] RUN_MAX   = RC_W'(MAX_CYCLES);

  state_e          state_q, state_d;
  logic [IA_W:0]   wr_ptr_q, wr_ptr_d;
  logic [DA_W:0]   rd_ptr_q, rd_ptr_d;
  logic [RC_W-1:0] run_cnt_q, run_cnt_d;
  logic            timeout_q, timeout_d;
  logic            ovf_q, ovf_d;
  logic            infl_q, infl_d;
  logic            infl_last_q, infl_last_d;
  logic            imem_we_c;
  logic            can_issue;
  logic            pop;
  logic            sb_in_ready;
  logic [1:0]      sb_count;
  logic [1:0]      occ_after;

  assign pop       = dp_valid && dp_ready;
  assign occ_after = sb_count - {1'b0, pop};

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    run_cnt_d   = run_cnt_q;
    timeout_d   = timeout_q;
    ovf_d       = ovf_q;
    infl_d      = 1'b0;
    infl_last_d = infl_last_q;
    ld_ready    = 1'b0;
    imem_we_c   = 1'b0;
    imem_wdata  = '0;
    cpu_run     = 1'b0;
    can_issue   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_LOAD;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          run_cnt_d = '0;
          timeout_d = 1'b0;
          ovf_d     = 1'b0;
        end
      end
      ST_LOAD: begin
        ld_ready   = 1'b1;
        imem_wdata = ld_data;
        if (ld_valid) begin
          if (wr_ptr_q < IMEM_FULL) begin
            imem_we_c = 1'b1;
            wr_ptr_d  = wr_ptr_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          if (ld_last) state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        if (wr_ptr_q < IMEM_FULL) begin
          imem_we_c  = 1'b1;
          imem_wdata = END_INSTR;
          wr_ptr_d   = wr_ptr_q + 1'b1;
          if (wr_ptr_q == IMEM_LAST) state_d = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cpu_run   = 1'b1;
        run_cnt_d = run_cnt_q + 1'b1;
        if (cpu_halt) begin
          state_d = ST_DUMP;
        end else if (run_cnt_d == RUN_MAX) begin
          state_d   = ST_DUMP;
          timeout_d = 1'b1;
        end
      end
      ST_DUMP: begin
        // Occupancy is counted after this cycle's pop so a steady stream keeps one read per cycle.
        can_issue = (rd_ptr_q < DMEM_FULL) && sb_in_ready &&
                    ((occ_after + {1'b0, infl_q}) < 2'd2);
        if (can_issue) begin
          rd_ptr_d    = rd_ptr_q + 1'b1;
          infl_d      = 1'b1;
          infl_last_d = (rd_ptr_q == DMEM_LAST);
        end
        if (pop && dp_last) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      run_cnt_q   <= '0;
      timeout_q   <= 1'b0;
      ovf_q       <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      run_cnt_q   <= run_cnt_d;
      timeout_q   <= timeout_d;
      ovf_q       <= ovf_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
    end
  end

  harness_skid_buf #(.W(WORD_W + 1)) u_skid (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .in_valid_i (infl_q),
    .in_ready_o (sb_in_ready),
    .in_data_i  ({infl_last_q, dmem_rdata}),
    .out_valid_o(dp_valid),
    .out_ready_i(dp_ready),
    .out_data_o ({dp_last, dp_data}),
    .count_o    (sb_count)
  );

  // RAM strobes are suppressed while RESET is high so an abort never touches memory.
  assign imem_we    = imem_we_c && !RESET;
  assign dmem_re    = can_issue && !RESET;
  assign imem_addr  = wr_ptr_q[IA_W-1:0];
  assign dmem_addr  = rd_ptr_q[DA_W-1:0];
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign timeout    = timeout_q;
  assign load_ovf   = ovf_q;
  assign run_cycles = run_cnt_q;

endmodule

// File: doc/cpu_test_harness_ctrl.md
Name: cpu_test_harness_ctrl

Overview:
Synthesizable controller that runs one CPU test end to end: it loads a program, runs the CPU, then reads out the data memory. The program arrives as a word stream and is written into instruction RAM. Any unwritten instruction slots are filled with the END instruction. The CPU is released until it halts or a cycle budget expires, then every data memory word is streamed out under backpressure. Sits between the CPU's instruction/data RAMs and a host or bench stream interface, replacing file-based load/dump.

Parameters:
WORD_W, 32, instruction/data word width
IMEM_DEPTH, 512, instruction RAM words
DMEM_DEPTH, 512, data RAM words dumped
MAX_CYCLES, 100, run-phase cycle budget before timeout
END_INSTR, all-ones (WORD_W bits), pad/end instruction value

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
start  in  1  begin a test (accepted in IDLE or DONE)
ld_valid  in  1  load word valid
ld_ready  out  1  load word accepted
ld_data  in  WORD_W  program word
ld_last  in  1  final program word
imem_we  out  1  instruction RAM write enable
imem_addr  out  clog2(IMEM_DEPTH)  instruction RAM address
imem_wdata  out  WORD_W  instruction RAM write data
cpu_run  out  1  CPU enable; CPU held when low
cpu_halt  in  1  CPU retired END_INSTR
dmem_re  out  1  data RAM read enable
dmem_addr  out  clog2(DMEM_DEPTH)  data RAM read address
dmem_rdata  in  WORD_W  read data, valid 1 cycle after dmem_re
dp_valid  out  1  dump word valid
dp_ready  in  1  dump word consumed
dp_data  out  WORD_W  dump word
dp_last  out  1  marks word DMEM_DEPTH-1
busy  out  1  state not IDLE/DONE
done  out  1  state DONE
timeout  out  1  run ended by budget, not halt
load_ovf  out  1  program longer than IMEM_DEPTH
run_cycles  out  clog2(MAX_CYCLES+1)  cycles spent in RUN

Behaviour:
- Reset: state IDLE. All outputs 0. Counters 0. Skid buffer emptied. RAM contents untouched. Reset mid-operation aborts immediately, with no further imem/dmem strobes.
- States: IDLE -> LOAD on start. LOAD -> PAD on accepted ld_last. PAD -> RUN when all slots are written. RUN -> DUMP on halt/timeout. DUMP -> DONE after dp_last handshake. DONE -> LOAD on start. start is ignored in LOAD/PAD/RUN/DUMP.
- Entering LOAD clears timeout, load_ovf, run_cycles and the address counters.
- LOAD:
  - ld_ready=1.
  - Each ld_valid&ld_ready writes imem_addr=wr_ptr in the same cycle (imem_we combinational from handshake, registered address), then wr_ptr++.
  - Once wr_ptr has reached IMEM_DEPTH, accepted words are dropped (imem_we=0) and load_ovf is set (sticky).
- PAD:
  - One END_INSTR write per cycle from wr_ptr to IMEM_DEPTH-1.
  - If wr_ptr==IMEM_DEPTH on entry, PAD lasts exactly 1 cycle with no write.
  - ld_ready=0.
- RUN:
  - cpu_run=1 every cycle; run_cycles increments each RUN cycle.
  - Exit when cpu_halt=1, with timeout=0, and cpu_run drops the next cycle.
  - Otherwise exit when run_cycles reaches MAX_CYCLES, with timeout=1.
  - Halt and budget in the same cycle: halt wins, timeout=0.
- DUMP:
  - Reads addresses 0..DMEM_DEPTH-1 in order.
  - A read is issued only if occupancy plus in-flight is less than 2 (2-entry skid buffer).
  - Sustains 1 word/cycle with dp_ready held high.
  - First dp_valid appears 2 cycles after DUMP entry.
  - dp_data/dp_valid/dp_last are stable while dp_valid&!dp_ready.
  - No word is lost or duplicated under any dp_ready pattern.
- Widths: counters are sized one bit wider than the address so they reach DEPTH without wrap. Addresses are truncated from counters.
- busy=1 in LOAD/PAD/RUN/DUMP.

Decomposition:
- Shared package holds:
  - state enum (IDLE, LOAD, PAD, RUN, DUMP, DONE)
  - END_INSTR default
  - address-width helper function
- One sub-module, harness_skid_buf: 2-entry WORD_W+1 valid/ready buffer, data plus last flag.

Test Plan:
1. IMEM_DEPTH=8; load 3 words (0x11, 0x22, 0x33 with last) -> imem addr 0–2 written with those words, addr 3–7 written with 0xFFFFFFFF; RUN entered on the cycle after addr 7 is written.
2. Load 10 words into IMEM_DEPTH=8 -> addr 0–7 written, words 9–10 dropped, load_ovf=1, no PAD writes.
3. cpu_halt pulsed in the 5th RUN cycle -> run_cycles=5, timeout=0, DUMP starts the next cycle.
4. cpu_halt never asserted, MAX_CYCLES=100 -> cpu_run high exactly 100 cycles, timeout=1.
5. DMEM_DEPTH=4, dmem_rdata=addr+0xA0, dp_ready toggling 1,0,0,1 -> dp_data sequence A0, A1, A2, A3 with no repeats; dp_last only with A3; done=1 after that handshake.
6. RESET asserted mid-DUMP, then start -> all outputs 0 the next cycle; a new LOAD begins with wr_ptr=0 and cleared flags.
